// File: rtl/program_ram_arbiter_pkg.sv
// Shared types for the program RAM arbiter: grant owner / response tag encoding,
// FSM states, the RAM write polarity and a saturating counter helper.
package tau_pram_arb_pkg;

   typedef enum logic [1:0] {
      ARB_NONE  = 2'b00,
      ARB_FETCH = 2'b01,
      ARB_DATA  = 2'b10
   } arb_owner_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_RESP = 1'b1
   } arb_state_t;

   localparam logic RW_WRITE        = 1'b1;
   localparam int   BURST_CNT_WIDTH = 4;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/program_ram_arbiter_if.sv
// Bus bundle between the two PRAM requesters, the arbiter and the single-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM environment.
interface program_ram_arbiter_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16
);

   logic                     fetch_req;
   logic [ADDRESS_WIDTH-1:0] fetch_addr;
   logic                     fetch_gnt;
   logic                     fetch_rvalid;
   logic [DATA_WIDTH-1:0]    fetch_rdata;

   logic                     data_req;
   logic                     data_rw;
   logic [ADDRESS_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0]    data_wdata;
   logic                     data_gnt;
   logic                     data_rvalid;
   logic [DATA_WIDTH-1:0]    data_rdata;

   logic                     ram_enable;
   logic                     ram_rw;
   logic [ADDRESS_WIDTH-1:0] ram_address;
   logic [DATA_WIDTH-1:0]    ram_data_in;
   logic [DATA_WIDTH-1:0]    ram_data_out;

   modport slave (
      input  fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, ram_data_out,
      output fetch_gnt, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata,
      output ram_enable, ram_rw, ram_address, ram_data_in
   );

   modport master (
      output fetch_req, fetch_addr, data_req, data_rw, data_addr, data_wdata, ram_data_out,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, data_gnt, data_rvalid, data_rdata,
      input  ram_enable, ram_rw, ram_address, ram_data_in
   );

endinterface

// File: rtl/program_ram_arbiter_grant_select.sv
// Combinational grant decision: data normally wins, but a fetch that has watched
// MAX_DATA_BURST consecutive data grants takes the RAM.
module arb_grant_select
   import tau_pram_arb_pkg::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                       fetch_req,
   input  logic                       data_req,
   input  logic [BURST_CNT_WIDTH-1:0] burst_cnt,
   output arb_owner_t                 owner
);

   localparam logic [BURST_CNT_WIDTH-1:0] MAX_CNT = BURST_CNT_WIDTH'(MAX_DATA_BURST);

   logic fetch_starved;

   assign fetch_starved = fetch_req && (burst_cnt == MAX_CNT);

   always_comb begin
      owner = ARB_NONE;
      if (data_req && !fetch_starved) begin
         owner = ARB_DATA;
      end else if (fetch_req) begin
         owner = ARB_FETCH;
      end
   end

endmodule

// File: rtl/program_ram_arbiter.sv
// Arbitrates the single-port program RAM between instruction fetch and load/store.
// Optional PRAM_ARB_STATS_EN adds saturating conflict_count / starve_count outputs.
module program_ram_arbiter
   import tau_pram_arb_pkg::*;
#(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   program_ram_arbiter_if.slave   bus,
   output logic                   busy
`ifdef PRAM_ARB_STATS_EN
   ,
   output logic [15:0]            conflict_count,
   output logic [15:0]            starve_count
`endif
);

   localparam logic [BURST_CNT_WIDTH-1:0] MAX_CNT = BURST_CNT_WIDTH'(MAX_DATA_BURST);

   arb_owner_t                 sel_owner;
   arb_owner_t                 owner;
   arb_owner_t                 tag_q;
   arb_owner_t                 tag_d;
   arb_state_t                 state_q;
   arb_state_t                 state_d;
   logic [BURST_CNT_WIDTH-1:0] burst_cnt;
   logic [ADDRESS_WIDTH-1:0]   addr_mux;
   logic [DATA_WIDTH-1:0]      fetch_hold;
   logic [DATA_WIDTH-1:0]      data_hold;

   arb_grant_select #(
      .MAX_DATA_BURST (MAX_DATA_BURST)
   ) u_grant_select (
      .fetch_req (bus.fetch_req),
      .data_req  (bus.data_req),
      .burst_cnt (burst_cnt),
      .owner     (sel_owner)
   );

   // Grants are suppressed while reset is asserted so nothing reaches the RAM.
   assign owner = reset_n ? sel_owner : ARB_NONE;

   // Drive the RAM from the granted requester and decide whether a read goes in flight.
   always_comb begin
      bus.fetch_gnt   = 1'b0;
      bus.data_gnt    = 1'b0;
      bus.ram_enable  = 1'b0;
      bus.ram_rw      = 1'b0;
      bus.ram_data_in = '0;
      addr_mux        = '0;
      tag_d           = ARB_NONE;
      case (owner)
         ARB_FETCH: begin
            bus.fetch_gnt  = 1'b1;
            bus.ram_enable = 1'b1;
            addr_mux       = bus.fetch_addr;
            tag_d          = ARB_FETCH;
         end
         ARB_DATA: begin
            bus.data_gnt    = 1'b1;
            bus.ram_enable  = 1'b1;
            bus.ram_rw      = bus.data_rw;
            addr_mux        = bus.data_addr;
            bus.ram_data_in = bus.data_wdata;
            if (bus.data_rw != RW_WRITE) begin
               tag_d = ARB_DATA;
            end
         end
         default: ;
      endcase
   end

   assign bus.ram_address = addr_mux;

   // RESP means a read was granted last cycle; each new read grant keeps it there.
   always_comb begin
      state_d = ARB_IDLE;
      case (state_q)
         ARB_IDLE: if (tag_d != ARB_NONE) state_d = ARB_RESP;
         ARB_RESP: if (tag_d != ARB_NONE) state_d = ARB_RESP;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ARB_IDLE;
         tag_q   <= ARB_NONE;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
      end
   end

   // The RAM output register already holds the word, so the response is steered, not re-registered.
   assign bus.fetch_rvalid = (tag_q == ARB_FETCH);
   assign bus.data_rvalid  = (tag_q == ARB_DATA);
   assign bus.fetch_rdata  = bus.fetch_rvalid ? bus.ram_data_out : fetch_hold;
   assign bus.data_rdata   = bus.data_rvalid  ? bus.ram_data_out : data_hold;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_hold <= '0;
         data_hold  <= '0;
      end else begin
         if (tag_q == ARB_FETCH) fetch_hold <= bus.ram_data_out;
         if (tag_q == ARB_DATA)  data_hold  <= bus.ram_data_out;
      end
   end

   // Counts data grants the waiting fetch has sat through; any fetch grant or withdrawal restarts it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         burst_cnt <= '0;
      end else if (!bus.fetch_req || owner == ARB_FETCH) begin
         burst_cnt <= '0;
      end else if (owner == ARB_DATA && burst_cnt != MAX_CNT) begin
         burst_cnt <= burst_cnt + 1'b1;
      end
   end

   assign busy = reset_n & ((state_q == ARB_RESP) | bus.fetch_req | bus.data_req);

`ifdef PRAM_ARB_STATS_EN
   // A fetch grant while data is also asking can only come from the starvation guard.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         conflict_count <= '0;
         starve_count   <= '0;
      end else begin
         if (bus.fetch_req && bus.data_req) conflict_count <= sat_inc16(conflict_count);
         if (owner == ARB_FETCH && bus.data_req) starve_count <= sat_inc16(starve_count);
      end
   end
`endif

endmodule

// File: tb/tb_program_ram_arbiter.sv
// Randomized + directed bench for program_ram_arbiter against a cycle-level reference
// model of the arbitration rules and a shadow copy of program memory.
module tb_program_ram_arbiter;

   localparam int MAX_BURST = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic busy;
`ifdef PRAM_ARB_STATS_EN
   logic [15:0] conflict_count;
   logic [15:0] starve_count;
`endif

   always #5 clock = ~clock;

   program_ram_arbiter_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(16)) bus ();

   program_ram_arbiter #(
      .ADDRESS_WIDTH  (16),
      .DATA_WIDTH     (16),
      .MAX_DATA_BURST (MAX_BURST)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus),
      .busy    (busy)
`ifdef PRAM_ARB_STATS_EN
      ,
      .conflict_count (conflict_count),
      .starve_count   (starve_count)
`endif
   );

   // Behavioural single-port synchronous RAM with a registered read port.
   logic [15:0] ram_mem [0:255];
   always @(posedge clock) begin
      if (bus.ram_enable) begin
         if (bus.ram_rw) ram_mem[bus.ram_address[7:0]] <= bus.ram_data_in;
         else            bus.ram_data_out <= ram_mem[bus.ram_address[7:0]];
      end
   end

   logic [15:0] ref_mem [0:255];
   int          m_burst;
   bit          m_fpend, m_dpend;
   logic [15:0] m_fval, m_dval, m_fhold, m_dhold;
   int          m_conflict, m_starve;
   bit          last_fgnt, last_dgnt, obs_fgnt;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      m_burst    = 0;
      m_fpend    = 0;
      m_dpend    = 0;
      m_fhold    = '0;
      m_dhold    = '0;
      m_fval     = '0;
      m_dval     = '0;
      m_conflict = 0;
      m_starve   = 0;
   endtask

   // Compare this cycle's outputs with the rules, then advance the model by one cycle.
   task automatic modelCycle();
      bit fr, dr, rw, exp_f, exp_d, forced;
      logic [15:0] fa, da, dw, exp_addr;
      fr = bus.fetch_req;
      dr = bus.data_req;
      rw = bus.data_rw;
      fa = bus.fetch_addr;
      da = bus.data_addr;
      dw = bus.data_wdata;
      forced   = fr && dr && (m_burst == MAX_BURST);
      exp_d    = dr && !forced;
      exp_f    = fr && !exp_d;
      exp_addr = exp_f ? fa : (exp_d ? da : 16'h0000);
      obs_fgnt = bus.fetch_gnt;
      checkOutput("fetch_gnt",    {31'd0, bus.fetch_gnt},    {31'd0, exp_f});
      checkOutput("data_gnt",     {31'd0, bus.data_gnt},     {31'd0, exp_d});
      checkOutput("ram_enable",   {31'd0, bus.ram_enable},   {31'd0, exp_f | exp_d});
      checkOutput("ram_rw",       {31'd0, bus.ram_rw},       {31'd0, exp_d & rw});
      checkOutput("ram_address",  {16'd0, bus.ram_address},  {16'd0, exp_addr});
      checkOutput("ram_data_in",  {16'd0, bus.ram_data_in},  {16'd0, exp_d ? dw : 16'h0000});
      checkOutput("fetch_rvalid", {31'd0, bus.fetch_rvalid}, {31'd0, m_fpend});
      checkOutput("data_rvalid",  {31'd0, bus.data_rvalid},  {31'd0, m_dpend});
      checkOutput("fetch_rdata",  {16'd0, bus.fetch_rdata},  {16'd0, m_fpend ? m_fval : m_fhold});
      checkOutput("data_rdata",   {16'd0, bus.data_rdata},   {16'd0, m_dpend ? m_dval : m_dhold});
      checkOutput("busy",         {31'd0, busy},             {31'd0, m_fpend | m_dpend | fr | dr});
`ifdef PRAM_ARB_STATS_EN
      checkOutput("conflict_count", {16'd0, conflict_count}, m_conflict);
      checkOutput("starve_count",   {16'd0, starve_count},   m_starve);
`endif
      if (m_fpend) m_fhold = m_fval;
      if (m_dpend) m_dhold = m_dval;
      m_fpend = exp_f;
      m_fval  = ref_mem[fa[7:0]];
      m_dpend = exp_d && !rw;
      m_dval  = ref_mem[da[7:0]];
      if (exp_d && rw) ref_mem[da[7:0]] = dw;
      if (!fr || exp_f)                       m_burst = 0;
      else if (exp_d && m_burst < MAX_BURST)  m_burst++;
      if (fr && dr && m_conflict < 65535) m_conflict++;
      if (forced && m_starve < 65535)     m_starve++;
      last_fgnt = exp_f;
      last_dgnt = exp_d;
   endtask

   task automatic applyStimulus(input bit fr, input logic [15:0] fa, input bit dr, input bit rw,
                                input logic [15:0] da, input logic [15:0] dw);
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
      bus.data_req   = dr;
      bus.data_rw    = rw;
      bus.data_addr  = da;
      bus.data_wdata = dw;
      @(negedge clock);
      modelCycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [9:0]  fetch_pattern;
      bit          fr, dr, rw;
      logic [15:0] fa, da, dw;

      reset_n          = 1'b0;
      bus.fetch_req    = 1'b1;
      bus.fetch_addr   = 16'h0020;
      bus.data_req     = 1'b1;
      bus.data_rw      = 1'b0;
      bus.data_addr    = 16'h0021;
      bus.data_wdata   = 16'h0000;
      bus.ram_data_out = 16'h0000;
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 16'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      ram_mem[3] = 16'h1A2B;
      ref_mem[3] = 16'h1A2B;
      resetModel();

      // Both requesters asking while held in reset: nothing may be granted.
      repeat (2) @(negedge clock);
      checkOutput("rst_fetch_gnt",  {31'd0, bus.fetch_gnt},  32'd0);
      checkOutput("rst_data_gnt",   {31'd0, bus.data_gnt},   32'd0);
      checkOutput("rst_ram_enable", {31'd0, bus.ram_enable}, 32'd0);
      checkOutput("rst_busy",       {31'd0, busy},           32'd0);
      checkOutput("rst_rdata",      {16'd0, bus.fetch_rdata}, 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      applyStimulus(1, 16'h0020, 1, 0, 16'h0021, 16'h0000);
      checkOutput("t1_release_data_first", {31'd0, obs_fgnt}, 32'd0);

      // Contention: fetch must break through after MAX_BURST data grants.
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 16'h0040, 1, 0, 16'h0050, 16'h0000);
         fetch_pattern[i] = obs_fgnt;
      end
      checkOutput("t4_grant_pattern", {22'd0, fetch_pattern}, 32'h210);

      applyStimulus(1, 16'h0003, 0, 0, 16'h0000, 16'h0000);
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      checkOutput("t2_fetch_rdata", {16'd0, bus.fetch_rdata}, 32'h1A2B);

      applyStimulus(0, 16'h0000, 1, 1, 16'h0010, 16'hBEEF);
      applyStimulus(0, 16'h0000, 1, 0, 16'h0010, 16'h0000);
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
      checkOutput("t3_data_rdata", {16'd0, bus.data_rdata}, 32'hBEEF);

      for (int i = 0; i < 8; i++) applyStimulus(1, 16'(i), 0, 0, 16'h0000, 16'h0000);
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);

      // Reset in the response cycle of a read must swallow the response.
      applyStimulus(1, 16'h0005, 0, 0, 16'h0000, 16'h0000);
      bus.fetch_req = 1'b0;
      reset_n       = 1'b0;
      #1;
      checkOutput("t6_rvalid_dropped", {31'd0, bus.fetch_rvalid}, 32'd0);
      checkOutput("t6_busy",           {31'd0, busy},             32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      resetModel();
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);

      fr = 0;
      dr = 0;
      rw = 0;
      fa = '0;
      da = '0;
      dw = '0;
      for (int c = 0; c < 400; c++) begin
         if (!fr || $urandom_range(0, 15) == 0) begin
            fr = ($urandom_range(0, 3) != 0);
            fa = 16'($urandom_range(0, 255));
         end
         if (!dr) begin
            dr = 1'($urandom_range(0, 1));
            rw = 1'($urandom_range(0, 1));
            da = 16'($urandom_range(0, 31));
            dw = 16'($urandom);
         end
         applyStimulus(fr, fa, dr, rw, da, dw);
         if (last_fgnt) fr = 0;
         if (last_dgnt) dr = 0;
      end
      applyStimulus(0, 16'h0000, 0, 0, 16'h0000, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
